// File: rtl/bsg_fsb_node_tx_arbiter.sv
// Round-robin, burst-limited arbiter that funnels nodes_p FSB node packets into one
// registered output slot feeding the comm link core side.
module bsg_fsb_node_tx_arbiter #(
    parameter int nodes_p      = 4,
    parameter int ring_width_p = 80,
    parameter int max_burst_p  = 4
) (
    input  logic                              core_clk_i,
    input  logic                              async_reset_n_i,
    input  logic [nodes_p-1:0]                node_en_i,
    input  logic [nodes_p-1:0]                node_v_i,
    input  logic [nodes_p*ring_width_p-1:0]   node_data_i,
    output logic [nodes_p-1:0]                node_yumi_o,
    output logic                              v_o,
    output logic [ring_width_p-1:0]           data_o,
    input  logic                              ready_i,
    output logic [$clog2(nodes_p)-1:0]        src_id_o
);

    localparam int id_width_lp  = $clog2(nodes_p);
    localparam int cnt_width_lp = $clog2(max_burst_p + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [id_width_lp-1:0]  last_id_lp   = id_width_lp'(nodes_p - 1);
    localparam logic [id_width_lp-1:0]  id_one_lp    = id_width_lp'(1);
    localparam logic [cnt_width_lp-1:0] burst_max_lp = cnt_width_lp'(max_burst_p);
    localparam logic [cnt_width_lp-1:0] cnt_one_lp   = cnt_width_lp'(1);
    localparam logic [0:0] after_grant_state_lp = (max_burst_p > 1) ? ST_BURST : ST_IDLE;

    logic [0:0]              state_reg;
    logic [id_width_lp-1:0]  last_grant_reg;   // doubles as the burst owner
    logic [cnt_width_lp-1:0] burst_cnt_reg;
    logic                    v_reg;
    logic [ring_width_p-1:0] data_reg;
    logic [id_width_lp-1:0]  src_id_reg;

    logic [nodes_p-1:0]      elig;
    logic [ring_width_p-1:0] node_data_arr [nodes_p];
    logic                    space;
    logic                    owner_ok;
    logic                    rr_found;
    logic [id_width_lp-1:0]  rr_idx;
    logic [id_width_lp-1:0]  cand;
    logic                    grant_v;
    logic [id_width_lp-1:0]  grant;
    logic                    yumi_any;

    assign elig  = node_v_i & node_en_i;
    assign space = ~v_reg | ready_i;

    genvar gi;
    generate
        for (gi = 0; gi < nodes_p; gi++) begin : g_node
            assign node_data_arr[gi] = node_data_i[gi*ring_width_p +: ring_width_p];
            assign node_yumi_o[gi]   = yumi_any & (grant == id_width_lp'(gi));
        end
    endgenerate

    // Round-robin search starts just past the last grant and visits it last, so a lone
    // eligible node can start a fresh burst once its previous one is exhausted.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = last_grant_reg;
        for (int k = 0; k < nodes_p; k++) begin
            cand = (cand == last_id_lp) ? '0 : cand + id_one_lp;
            if (!rr_found && elig[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    assign owner_ok = (state_reg == ST_BURST) && elig[last_grant_reg]
                      && (burst_cnt_reg < burst_max_lp);
    assign grant_v  = owner_ok | rr_found;
    assign grant    = owner_ok ? last_grant_reg : rr_idx;
    assign yumi_any = async_reset_n_i & space & grant_v;

    // A fallback grant out of a broken burst is treated exactly like an IDLE grant:
    // the new node starts its own burst with count 1.
    always_ff @(posedge core_clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= last_id_lp;
            burst_cnt_reg  <= '0;
            v_reg          <= 1'b0;
            data_reg       <= '0;
            src_id_reg     <= '0;
        end else if (space) begin
            v_reg <= grant_v;
            if (grant_v) begin
                data_reg   <= node_data_arr[grant];
                src_id_reg <= grant;
            end
            if (owner_ok) begin
                burst_cnt_reg <= burst_cnt_reg + cnt_one_lp;
                if (burst_cnt_reg + cnt_one_lp == burst_max_lp) begin
                    state_reg <= ST_IDLE;
                end
            end else if (rr_found) begin
                last_grant_reg <= rr_idx;
                burst_cnt_reg  <= cnt_one_lp;
                state_reg      <= after_grant_state_lp;
            end else begin
                state_reg     <= ST_IDLE;
                burst_cnt_reg <= '0;
            end
        end
    end

    assign v_o      = v_reg;
    assign data_o   = data_reg;
    assign src_id_o = src_id_reg;

`ifndef SYNTHESIS
    a_yumi_onehot: assert property (@(posedge core_clk_i) disable iff (!async_reset_n_i)
        $onehot0(node_yumi_o));
    a_yumi_elig: assert property (@(posedge core_clk_i) disable iff (!async_reset_n_i)
        ((node_yumi_o & ~elig) == '0));
`endif

endmodule

// File: tb/tb_bsg_fsb_node_tx_arbiter.sv
// Directed bench for bsg_fsb_node_tx_arbiter: a packet-level arbitration model is checked
// every cycle, and literal expectations pin the reset, burst, backpressure and mask cases.
module tb_bsg_fsb_node_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 80;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   en;
    logic [N-1:0]   v;
    logic [N*W-1:0] data;
    logic [N-1:0]   yumi;
    logic           vo;
    logic [W-1:0]   dout;
    logic           ready;
    logic [1:0]     src;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int burst_seq [17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    logic [W-1:0] held_exp;

    bsg_fsb_node_tx_arbiter #(.nodes_p(N), .ring_width_p(W), .max_burst_p(MB)) dut (
        .core_clk_i      (clk),
        .async_reset_n_i (rst_n),
        .node_en_i       (en),
        .node_v_i        (v),
        .node_data_i     (data),
        .node_yumi_o     (yumi),
        .v_o             (vo),
        .data_o          (dout),
        .ready_i         (ready),
        .src_id_o        (src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every node offers a fresh, distinguishable packet every cycle.
    task automatic load_data();
        for (int i = 0; i < N; i++)
            data[i*W +: W] = {8'(i), 8'hC3, 32'(cyc), 32'hDEAD0000 + 32'(i)};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        load_data();
    endtask

    task automatic reset_pulse();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Packet-level model: the current owner keeps the slot while it is eligible and has
    // sent fewer than MB packets; otherwise the next eligible node after it wins.
    int           m_owner = N - 1;
    int           m_run   = 0;
    bit           m_v     = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_src   = 0;

    always @(negedge clk) begin : cmp
        logic [N-1:0] e;
        logic [N-1:0] ey;
        int g;
        bit sp;
        if (!rst_n) begin
            chk("rst_yumi", W'(yumi), W'(0));
            chk("rst_v", W'(vo), W'(0));
            m_owner = N - 1;
            m_run   = 0;
            m_v     = 1'b0;
            m_data  = '0;
            m_src   = 0;
        end else begin
            e = v & en;
            g = -1;
            if (m_run > 0 && m_run < MB && e[m_owner]) g = m_owner;
            else
                for (int k = 1; k <= N; k++)
                    if (g < 0 && e[(m_owner + k) % N]) g = (m_owner + k) % N;
            sp = !m_v || ready;
            ey = '0;
            if (sp && g >= 0) ey[g] = 1'b1;
            chk("yumi", W'(yumi), W'(ey));
            chk("v_o", W'(vo), W'(m_v));
            if (m_v) begin
                chk("data_o", dout, m_data);
                chk("src_id", W'(src), W'(m_src));
            end
            if (sp) begin
                m_v = (g >= 0);
                if (g >= 0) begin
                    m_data = data[g*W +: W];
                    m_src  = g;
                    if (g == m_owner && m_run > 0 && m_run < MB) m_run++;
                    else begin
                        m_owner = g;
                        m_run   = 1;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
    end

    initial begin
        en = 4'hF; v = 4'hF; ready = 1'b1;
        load_data();

        // 1: reset with every node requesting, then node 0 first
        repeat (4) tick();
        @(negedge clk);
        chk("t1_v_in_reset", W'(vo), W'(0));
        chk("t1_yumi_in_reset", W'(yumi), W'(0));
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_first_yumi", W'(yumi), W'(4'b0001));

        // 2: full-rate bursts of four, rotating
        for (int k = 0; k < 17; k++) begin
            tick();
            @(negedge clk);
            chk("t2_v", W'(vo), W'(1));
            chk("t2_src", W'(src), W'(burst_seq[k]));
        end

        // 3: backpressure holds node 0's packet
        held_exp = data[0 +: W];
        tick();
        ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t3_hold_data", dout, held_exp);
            chk("t3_hold_src", W'(src), W'(0));
            chk("t3_hold_v", W'(vo), W'(1));
            chk("t3_no_yumi", W'(yumi), W'(0));
            tick();
        end
        ready = 1'b1;
        @(negedge clk);
        chk("t3_yumi_on_ready", W'(yumi), W'(4'b0001));
        tick();
        @(negedge clk);
        chk("t3_v_stays", W'(vo), W'(1));
        chk("t3_new_pkt", W'(dout != held_exp), W'(1));

        // 4: node 1 drops after two packets, node 3 takes over without a bubble
        v = 4'b1010;
        reset_pulse();
        @(negedge clk);
        chk("t4_yumi_n1_a", W'(yumi), W'(4'b0010));
        tick();
        @(negedge clk);
        chk("t4_yumi_n1_b", W'(yumi), W'(4'b0010));
        tick();
        v = 4'b1000;
        @(negedge clk);
        chk("t4_yumi_n3", W'(yumi), W'(4'b1000));
        chk("t4_src_n1", W'(src), W'(1));
        tick();
        @(negedge clk);
        chk("t4_v_no_bubble", W'(vo), W'(1));
        chk("t4_src_n3", W'(src), W'(3));

        // 5: enable mask 1010 alternates bursts between nodes 1 and 3
        v = 4'hF; en = 4'b1010;
        reset_pulse();
        for (int k = 0; k < 12; k++) begin
            tick();
            @(negedge clk);
            chk("t5_src", W'(src), W'(((k / 4) % 2 == 1) ? 3 : 1));
            chk("t5_masked_yumi", W'(yumi & 4'b0101), W'(0));
        end
        reset_pulse();
        @(negedge clk);
        chk("t5_yumi_n1_a", W'(yumi), W'(4'b0010));
        tick();
        @(negedge clk);
        chk("t5_yumi_n1_b", W'(yumi), W'(4'b0010));
        tick();
        en = 4'b1000;
        @(negedge clk);
        chk("t5_disable_owner", W'(yumi), W'(4'b1000));

        // 6: asynchronous reset while a packet is stalled in the slot
        en = 4'hF; v = 4'hF; ready = 1'b1;
        reset_pulse();
        tick();
        tick();
        ready = 1'b0;
        #2;
        chk("t6_v_before", W'(vo), W'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_v_async", W'(vo), W'(0));
        chk("t6_data_async", dout, W'(0));
        chk("t6_src_async", W'(src), W'(0));
        chk("t6_yumi_async", W'(yumi), W'(0));
        ready = 1'b1;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_first_yumi", W'(yumi), W'(4'b0001));
        tick();
        @(negedge clk);
        chk("t6_v_after", W'(vo), W'(1));
        chk("t6_src_after", W'(src), W'(0));

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
